// File: rtl/switch_readback_packer_if.sv
// switch_readback_packer_if: control, readback-FIFO and memory-write bus of the
// switch readback packer. The timeout_err flag exists only when
// SWITCH_PACKER_TIMEOUT_EN is defined.
interface switch_readback_packer_if #(
    parameter int WORD_WIDTH           = 128,
    parameter int SAMPLE_WIDTH         = 7,
    parameter int MAX_BITMAP_MEM_DEPTH = 2048
);
    localparam int ADDR_WIDTH = $clog2(MAX_BITMAP_MEM_DEPTH);

    logic                    start;
    logic [ADDR_WIDTH-1:0]   base_addr;
    logic [31:0]             num_samples;
    logic                    fifo_empty;
    logic                    fifo_rd;
    logic [SAMPLE_WIDTH-1:0] fifo_data;
    logic                    mem_wren;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [WORD_WIDTH-1:0]   mem_data;
    logic                    busy;
    logic                    done;
`ifdef SWITCH_PACKER_TIMEOUT_EN
    logic                    timeout_err;

    modport master (
        output start, base_addr, num_samples, fifo_empty, fifo_data,
        input  fifo_rd, mem_wren, mem_addr, mem_data, busy, done, timeout_err
    );

    modport slave (
        input  start, base_addr, num_samples, fifo_empty, fifo_data,
        output fifo_rd, mem_wren, mem_addr, mem_data, busy, done, timeout_err
    );
`else
    modport master (
        output start, base_addr, num_samples, fifo_empty, fifo_data,
        input  fifo_rd, mem_wren, mem_addr, mem_data, busy, done
    );

    modport slave (
        input  start, base_addr, num_samples, fifo_empty, fifo_data,
        output fifo_rd, mem_wren, mem_addr, mem_data, busy, done
    );
`endif
endinterface

// File: rtl/switch_readback_packer.sv
// switch_readback_packer: reads narrow switch-state samples from the readback
// FIFO and packs them, first sample in the LSBs, into WORD_WIDTH-bit words that
// are written to consecutive bitmap memory addresses starting at base_addr.
// Optional feature macro: SWITCH_PACKER_TIMEOUT_EN adds an empty-FIFO stall
// timeout that flushes the partial word and raises the sticky timeout_err flag.
module switch_readback_packer #(
    parameter int WORD_WIDTH           = 128,
    parameter int SAMPLE_WIDTH         = 7,
    parameter int MAX_BITMAP_MEM_DEPTH = 2048,
    parameter int TIMEOUT_CYCLES       = 1024
) (
    input  logic                     clock,
    input  logic                     reset,
    switch_readback_packer_if.slave  bus
);
    localparam int ADDR_WIDTH = $clog2(MAX_BITMAP_MEM_DEPTH);
    localparam int SPW        = WORD_WIDTH / SAMPLE_WIDTH;
    localparam int SLOT_WIDTH = (SPW > 1) ? $clog2(SPW) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        FIN
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   base_latched;
    logic [ADDR_WIDTH-1:0]   word_index;
    logic [31:0]             num_latched;
    logic [31:0]             issued;
    logic [31:0]             captured;
    logic [SLOT_WIDTH-1:0]   slot;
    logic [WORD_WIDTH-1:0]   assembly;
    logic [WORD_WIDTH-1:0]   merged;
    logic                    rd_valid;
    logic                    start_accept;
    logic                    last_capture;
    logic                    word_complete;
    logic                    timeout_hit;
    logic                    flush_now;
    logic                    mem_wren;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [WORD_WIDTH-1:0]   mem_data;

    assign start_accept  = (state == IDLE) && bus.start;
    assign bus.fifo_rd   = (state == RUN) && !bus.fifo_empty && (issued < num_latched);
    assign last_capture  = rd_valid && ((captured + 32'd1) == num_latched);
    assign word_complete = rd_valid && ((slot == SLOT_WIDTH'(SPW - 1)) || last_capture);
    assign flush_now     = timeout_hit && (slot != '0);
    assign bus.busy      = (state == RUN) || (state == FLUSH);
    assign bus.done      = (state == FIN);
    assign bus.mem_wren  = mem_wren;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_data  = mem_data;

`ifdef SWITCH_PACKER_TIMEOUT_EN
    localparam int STALL_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    logic [STALL_WIDTH-1:0] stall_count;
    logic                   timeout_err;

    assign timeout_hit     = (state == RUN) && (stall_count == STALL_WIDTH'(TIMEOUT_CYCLES));
    assign bus.timeout_err = timeout_err;

    // Count consecutive empty-FIFO cycles in RUN; any read restarts the count.
    always_ff @(posedge clock) begin
        if (reset || start_accept || bus.fifo_rd) begin
            stall_count <= '0;
        end else if ((state == RUN) && bus.fifo_empty && !timeout_hit) begin
            stall_count <= stall_count + STALL_WIDTH'(1);
        end
    end

    // Sticky error flag, cleared only by reset or by the next accepted start.
    always_ff @(posedge clock) begin
        if (reset || start_accept) begin
            timeout_err <= 1'b0;
        end else if (timeout_hit) begin
            timeout_err <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Drop the arriving sample into its slot of the word being assembled.
    always_comb begin
        merged = assembly |
                 ({{(WORD_WIDTH - SAMPLE_WIDTH){1'b0}}, bus.fifo_data} << (32'(slot) * SAMPLE_WIDTH));
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a zero-length job goes straight to FIN.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = (bus.num_samples == 32'd0) ? FIN : RUN;
            RUN:     if (last_capture || timeout_hit) state_next = FLUSH;
            FLUSH:   state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: latch the job, count reads and captures, assemble and emit words.
    always_ff @(posedge clock) begin
        if (reset) begin
            base_latched <= '0;
            num_latched  <= '0;
            issued       <= '0;
            captured     <= '0;
            word_index   <= '0;
            slot         <= '0;
            assembly     <= '0;
            rd_valid     <= 1'b0;
            mem_wren     <= 1'b0;
            mem_addr     <= '0;
            mem_data     <= '0;
        end else begin
            rd_valid <= bus.fifo_rd;
            mem_wren <= 1'b0;
            if (start_accept) begin
                base_latched <= bus.base_addr;
                num_latched  <= bus.num_samples;
                issued       <= '0;
                captured     <= '0;
                word_index   <= '0;
                slot         <= '0;
                assembly     <= '0;
            end else begin
                if (bus.fifo_rd) begin
                    issued <= issued + 32'd1;
                end
                if (rd_valid) begin
                    captured <= captured + 32'd1;
                end
                if (word_complete || flush_now) begin
                    mem_data   <= word_complete ? merged : assembly;
                    mem_wren   <= 1'b1;
                    mem_addr   <= base_latched + word_index;
                    word_index <= word_index + ADDR_WIDTH'(1);
                    assembly   <= '0;
                    slot       <= '0;
                end else if (rd_valid) begin
                    assembly <= merged;
                    slot     <= slot + SLOT_WIDTH'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_switch_readback_packer.sv
// tb_switch_readback_packer: self-checking bench for switch_readback_packer.
// A FIFO model feeds samples, a monitor records memory writes and strobes, and
// expected words are rebuilt from the sample list with plain arithmetic.
module tb_switch_readback_packer;
    localparam int WORD_WIDTH     = 128;
    localparam int SAMPLE_WIDTH   = 7;
    localparam int DEPTH          = 2048;
    localparam int SPW            = WORD_WIDTH / SAMPLE_WIDTH;
    localparam int TIMEOUT_CYCLES = 16;

    typedef struct {
        string          name;
        int             base;
        int             n;
        int             kind;
        int             stall;
        int             gap_after;
        int             gap_len;
        int             exp_words;
        int             exp_done_off;
        int             exp_last_addr;
        bit             chk_last;
        logic [127:0]   exp_last_data;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   failures = 0;

    switch_readback_packer_if #(
        .WORD_WIDTH(WORD_WIDTH), .SAMPLE_WIDTH(SAMPLE_WIDTH), .MAX_BITMAP_MEM_DEPTH(DEPTH)
    ) bus ();

    switch_readback_packer #(
        .WORD_WIDTH(WORD_WIDTH), .SAMPLE_WIDTH(SAMPLE_WIDTH),
        .MAX_BITMAP_MEM_DEPTH(DEPTH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    // Free-running clock and cycle counter.
    initial forever #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Hard time limit so the run always ends.
    initial begin
        #800000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    logic [6:0]   feed[$];
    int           rd_ptr = 0;
    int           run_base = 0;
    int           gap_after = -1;
    int           gap_len = 0;
    int           gap_left = 0;
    int           stall_pct = 0;
    int           flush_req = 0;
    int           flush_seen = 0;
    logic         rd_seen = 1'b0;

    // FIFO model: data valid the cycle after a read, empty when drained or stalled.
    always @(posedge clock) begin
        if (rd_seen && (rd_ptr < feed.size())) begin
            bus.fifo_data <= feed[rd_ptr];
            rd_ptr = rd_ptr + 1;
            if ((rd_ptr - run_base) == gap_after) gap_left = gap_len;
        end
        if (flush_req != flush_seen) begin
            rd_ptr     = feed.size();
            flush_seen = flush_req;
            gap_left   = 0;
        end
        if (gap_left > 0) begin
            bus.fifo_empty <= 1'b1;
            gap_left = gap_left - 1;
        end else begin
            bus.fifo_empty <= (rd_ptr >= feed.size()) || ($urandom_range(99) < stall_pct);
        end
    end

    logic [10:0]  wr_addr[$];
    logic [127:0] wr_data[$];
    int           rd_total = 0;
    int           rd_empty_total = 0;
    int           done_total = 0;
    int           done_cycle = 0;
    logic         busy_at_done = 1'b0;
    logic         tout_at_done = 1'b0;

    // Monitor on the falling edge: record writes, reads, done pulses.
    always @(negedge clock) begin
        rd_seen = bus.fifo_rd;
        if (bus.mem_wren) begin
            wr_addr.push_back(bus.mem_addr);
            wr_data.push_back(bus.mem_data);
        end
        if (bus.fifo_rd) rd_total = rd_total + 1;
        if (bus.fifo_rd && bus.fifo_empty) rd_empty_total = rd_empty_total + 1;
        if (bus.done) begin
            done_total   = done_total + 1;
            done_cycle   = cyc;
            busy_at_done = bus.busy;
`ifdef SWITCH_PACKER_TIMEOUT_EN
            tout_at_done = bus.timeout_err;
`else
            tout_at_done = 1'b0;
`endif
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        tests = tests + 1;
        if (actual !== expected) begin
            failures = failures + 1;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkCount(input string name, input int actual, input int expected);
        tests = tests + 1;
        if (actual != expected) begin
            failures = failures + 1;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Expected word k of a job: samples k*SPW.. packed LSB-first, rest zero.
    function automatic logic [127:0] modelWord(input logic [6:0] s[$], input int k);
        logic [127:0] w;
        w = '0;
        for (int j = 0; j < SPW; j++) begin
            if ((k * SPW + j) < s.size()) w = w | (128'(s[k * SPW + j]) << (SAMPLE_WIDTH * j));
        end
        return w;
    endfunction

    function automatic void buildSamples(input int kind, input int n, output logic [6:0] s[$]);
        s = {};
        for (int i = 0; i < n; i++) begin
            case (kind)
                0:       s.push_back(7'h7f);
                1:       s.push_back(7'(i + 1));
                default: s.push_back(7'($urandom));
            endcase
        end
    endfunction

    // Load the samples into the FIFO model and pulse start; returns in cycle T+1.
    task automatic applyStimulus(input int base, input int n, input logic [6:0] s[$], output int t0);
        tick();
        run_base = feed.size();
        foreach (s[i]) feed.push_back(s[i]);
        t0 = cyc;
        bus.start       = 1'b1;
        bus.base_addr   = 11'(base);
        bus.num_samples = 32'(n);
        tick();
        bus.start = 1'b0;
    endtask

    task automatic waitDone(input int d0, input int budget);
        int guard;
        guard = 0;
        while ((done_total == d0) && (guard < budget)) begin
            tick();
            guard++;
        end
    endtask

    task automatic runJob(input vec_t v);
        logic [6:0] s[$];
        int wr0, rd0, re0, d0, t0, nw;
        buildSamples(v.kind, v.n, s);
        wr0 = wr_addr.size(); rd0 = rd_total; re0 = rd_empty_total; d0 = done_total;
        stall_pct = v.stall; gap_after = v.gap_after; gap_len = v.gap_len;
        applyStimulus(v.base, v.n, s, t0);
        checkCount({v.name, " busy after start"}, int'(bus.busy), 1);
        waitDone(d0, 3000);
        checkCount({v.name, " done pulses"}, done_total - d0, 1);
        if (v.exp_done_off >= 0) checkCount({v.name, " done latency"}, done_cycle - t0, v.exp_done_off);
        checkCount({v.name, " busy at done"}, int'(busy_at_done), 0);
        checkCount({v.name, " fifo reads"}, rd_total - rd0, v.n);
        checkCount({v.name, " reads while empty"}, rd_empty_total - re0, 0);
        nw = (v.n + SPW - 1) / SPW;
        checkCount({v.name, " word count"}, wr_addr.size() - wr0, (v.exp_words >= 0) ? v.exp_words : nw);
        for (int k = 0; k < nw; k++) begin
            if ((wr0 + k) < wr_addr.size()) begin
                checkCount($sformatf("%s addr%0d", v.name, k), int'(wr_addr[wr0 + k]), (v.base + k) % DEPTH);
                checkOutput($sformatf("%s data%0d", v.name, k), wr_data[wr0 + k], modelWord(s, k));
            end
        end
        if ((v.exp_last_addr >= 0) && (wr_addr.size() > wr0))
            checkCount({v.name, " last addr"}, int'(wr_addr[wr_addr.size() - 1]), v.exp_last_addr);
        if (v.chk_last && (wr_data.size() > wr0))
            checkOutput({v.name, " last data"}, wr_data[wr_data.size() - 1], v.exp_last_data);
`ifdef SWITCH_PACKER_TIMEOUT_EN
        checkCount({v.name, " timeout flag"}, int'(tout_at_done), 0);
`endif
        stall_pct = 0; gap_after = -1; gap_len = 0;
        tick();
        tick();
    endtask

    vec_t vecs[6];

    initial begin
        logic [6:0] s[$];
        int wr0, rd0, d0, t0, guard;
        vec_t rv;

        vecs[0] = '{"full18",  5,    18, 0, 0,  -1, 0,  1, 21, 5,   1'b1, {2'b00, {126{1'b1}}}};
        vecs[1] = '{"inc37",   100,  37, 1, 0,  -1, 0,  3, 40, 102, 1'b1, 128'h25};
        vecs[2] = '{"gap37",   100,  37, 1, 0,  5,  10, 3, -1, 102, 1'b1, 128'h25};
        vecs[3] = '{"wrap36",  2047, 36, 1, 0,  -1, 0,  2, 39, 0,   1'b0, 128'h0};
        vecs[4] = '{"single",  0,    1,  2, 0,  -1, 0,  1, 4,  0,   1'b0, 128'h0};
        vecs[5] = '{"wrap40s", 2046, 40, 1, 20, -1, 0,  3, -1, 0,   1'b1, 128'h509D325};

        bus.start = 1'b0;
        bus.base_addr = '0;
        bus.num_samples = '0;
        reset = 1'b1;
        repeat (3) tick();
        checkCount("reset fifo_rd", int'(bus.fifo_rd), 0);
        checkCount("reset mem_wren", int'(bus.mem_wren), 0);
        checkCount("reset busy", int'(bus.busy), 0);
        checkCount("reset done", int'(bus.done), 0);
        checkCount("reset mem_addr", int'(bus.mem_addr), 0);
        checkOutput("reset mem_data", bus.mem_data, 128'h0);
`ifdef SWITCH_PACKER_TIMEOUT_EN
        checkCount("reset timeout_err", int'(bus.timeout_err), 0);
`endif
        reset = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) runJob(vecs[i]);

        for (int r = 0; r < 20; r++) begin
            rv.name = $sformatf("rand%0d", r);
            rv.base = int'($urandom_range(DEPTH - 1));
            rv.n = int'($urandom_range(60, 1));
            rv.kind = 2;
            rv.stall = ($urandom_range(1) == 0) ? 0 : 25;
            rv.gap_after = -1;
            rv.gap_len = 0;
            rv.exp_words = -1;
            rv.exp_done_off = (rv.stall == 0) ? rv.n + 3 : -1;
            rv.exp_last_addr = -1;
            rv.chk_last = 1'b0;
            rv.exp_last_data = '0;
            runJob(rv);
        end

        // Reset in the middle of a job: outputs clear, partial word is dropped.
        buildSamples(1, 30, s);
        wr0 = wr_addr.size(); rd0 = rd_total;
        applyStimulus(300, 30, s, t0);
        guard = 0;
        while (((rd_total - rd0) < 10) && (guard < 200)) begin
            tick();
            guard++;
        end
        checkCount("midreset reads reached", int'((rd_total - rd0) >= 10), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkCount("midreset fifo_rd", int'(bus.fifo_rd), 0);
        checkCount("midreset mem_wren", int'(bus.mem_wren), 0);
        checkCount("midreset busy", int'(bus.busy), 0);
        checkCount("midreset done", int'(bus.done), 0);
        checkCount("midreset mem_addr", int'(bus.mem_addr), 0);
        checkOutput("midreset mem_data", bus.mem_data, 128'h0);
        repeat (40) tick();
        checkCount("midreset writes", wr_addr.size() - wr0, 0);
        checkCount("midreset stays idle", int'(bus.busy), 0);
        flush_req = flush_req + 1;
        repeat (2) tick();

        // Zero-length job, with a second start landing on the done cycle.
        buildSamples(2, 5, s);
        run_base = feed.size();
        foreach (s[i]) feed.push_back(s[i]);
        wr0 = wr_addr.size(); rd0 = rd_total; d0 = done_total;
        bus.start = 1'b1; bus.num_samples = 32'd0; bus.base_addr = 11'd9;
        tick();
        checkCount("zero done at T+1", int'(bus.done), 1);
        checkCount("zero busy at T+1", int'(bus.busy), 0);
        bus.start = 1'b1; bus.num_samples = 32'd5;
        tick();
        bus.start = 1'b0;
        checkCount("zero second start busy", int'(bus.busy), 0);
        checkCount("zero done single pulse", int'(bus.done), 0);
        repeat (10) tick();
        checkCount("zero fifo reads", rd_total - rd0, 0);
        checkCount("zero writes", wr_addr.size() - wr0, 0);
        checkCount("zero done pulses", done_total - d0, 1);
        flush_req = flush_req + 1;
        repeat (2) tick();

`ifdef SWITCH_PACKER_TIMEOUT_EN
        // Four samples then a permanently empty FIFO: timeout flushes the partial word.
        buildSamples(2, 4, s);
        wr0 = wr_addr.size(); rd0 = rd_total; d0 = done_total;
        applyStimulus(700, 10, s, t0);
        waitDone(d0, 300);
        checkCount("timeout done pulses", done_total - d0, 1);
        checkCount("timeout flag", int'(tout_at_done), 1);
        checkCount("timeout fifo reads", rd_total - rd0, 4);
        checkCount("timeout writes", wr_addr.size() - wr0, 1);
        if (wr_addr.size() > wr0) begin
            checkCount("timeout addr", int'(wr_addr[wr0]), 700);
            checkOutput("timeout data", wr_data[wr0], modelWord(s, 0));
        end
        repeat (2) tick();
        rv = '{"after_timeout", 3, 1, 2, 0, -1, 0, 1, 4, 3, 1'b0, 128'h0};
        runJob(rv);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule

// File: doc/switch_readback_packer.md
# switch_readback_packer

Collects NUM_SWITCHES-wide switch-state samples from a readback FIFO and packs them into WORD_WIDTH-bit words. It writes those words sequentially into a port of the dual-port bitmap memory. It is the inverse of the bitmap-to-switch shift path: that path unpacks memory words into narrow FIFO entries, and this block rebuilds memory words from narrow FIFO entries so the controller can re-encrypt or hash the captured switch history.

## Interface
- WORD_WIDTH, 128, memory word width in bits.
- SAMPLE_WIDTH, 7, FIFO entry width (equals NUM_SWITCHES).
- MAX_BITMAP_MEM_DEPTH, 2048, memory depth; ADDR_WIDTH = `CLOG2(MAX_BITMAP_MEM_DEPTH).
- TIMEOUT_CYCLES, 1024, empty-FIFO stall limit; used only when the timeout feature is compiled in.
- Derived: SPW = WORD_WIDTH / SAMPLE_WIDTH, the samples per word (18 at defaults).

Ports:
- clock  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- start  in  1  single-cycle request; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first memory address written; latched on start.
- num_samples  in  32  total samples to capture; latched on start.
- fifo_empty  in  1  readback FIFO empty.
- fifo_rd  out  1  FIFO read strobe.
- fifo_data  in  SAMPLE_WIDTH  FIFO read data; valid the cycle after fifo_rd.
- mem_wren  out  1  memory write enable, one cycle per word.
- mem_addr  out  ADDR_WIDTH  write address.
- mem_data  out  WORD_WIDTH  packed word.
- busy  out  1  high from the cycle after start until done.
- done  out  1  single-cycle pulse at completion.
- timeout_err  out  1  sticky error flag; cleared on start. Present only with the timeout feature.

## Operation
- States:
  - IDLE: start=1 goes to RUN; start=1 with num_samples=0 goes to FIN.
  - RUN: moves to FLUSH once all samples have been captured.
  - FLUSH: writes the final partial word, if any, then moves to FIN.
  - FIN: asserts done, returns to IDLE.
- fifo_rd = (state==RUN) && !fifo_empty && (issued < num_samples_latched). The block never reads an empty FIFO and never over-reads.
- rd_valid is fifo_rd delayed one cycle. When rd_valid=1, fifo_data is inserted into slot `slot` of the assembly register, bits [slot*SAMPLE_WIDTH +: SAMPLE_WIDTH].
- Packing order: the first sample goes in the LSBs. The top WORD_WIDTH − SPW·SAMPLE_WIDTH bits (2 at defaults) are always 0.
- When slot reaches SPW−1, or the last sample is captured:
  - the assembled word (with the new sample included) is copied to the output register;
  - mem_wren is asserted the next cycle;
  - the assembly register is cleared and slot resets to 0.
  - A sample arriving in that same cycle lands in slot 0 of the cleared register. There is no stall, so throughput is 1 sample/cycle.
- Unused slots of the final word read 0.
- mem_addr = base_addr + word_index, modulo 2^ADDR_WIDTH, so the address wraps from MAX_BITMAP_MEM_DEPTH−1 to 0.
- Counters: issued and captured are 32-bit; word_index is ADDR_WIDTH bits.
- start while busy is ignored. base_addr and num_samples are ignored outside IDLE.
- Reset at any point: state goes to IDLE. fifo_rd=0, mem_wren=0, busy=0, done=0, timeout_err=0, mem_addr=0, mem_data=0. Counters and the assembly register are cleared. A partial word is discarded and no write is issued.

## Timing
- Start accepted in cycle T: busy=1 at T+1; earliest fifo_rd at T+1.
- A sample read at cycle t is captured at the edge ending t+1.
- mem_wren is at t+2 when that sample completes a word.
- done pulses in the cycle after the final mem_wren; busy drops in the same cycle done rises.
- With num_samples=0: done at T+1, no mem_wren, busy stays 0.
- Minimum run time with a never-empty FIFO is num_samples + 3 cycles, start to done inclusive.
- FIFO empty mid-run: fifo_rd holds 0. The assembly register and slot hold their values, and the run resumes when the FIFO refills.

## Configuration
- SWITCH_PACKER_TIMEOUT_EN defined:
  - A stall counter increments each RUN cycle with fifo_empty=1 and clears on each fifo_rd.
  - When it reaches TIMEOUT_CYCLES, timeout_err is set, the partial word is flushed (zero-padded) through the normal FLUSH/FIN path, and done pulses.
- Not defined: no counter and no timeout_err port. The block waits on an empty FIFO indefinitely.

## Test plan
- 18 samples of value 0x7F, FIFO always non-empty, base_addr=5 → one write: addr 5, data 0x3FFF…FFF (bits 125:0 set, 127:126 = 0). done at start + 21 cycles.
- 37 samples, incrementing from 1 → writes at base, base+1, base+2. The third word is 0x25 with all other bits 0. Exactly 37 fifo_rd pulses.
- FIFO empty for 10 cycles after sample 5 → no fifo_rd while empty. The final word is identical to the no-gap run.
- num_samples=0 → done at T+1, zero mem_wren, zero fifo_rd. A second start in the same cycle as done is ignored.
- base_addr=2047, 36 samples → writes to 2047, then 0.
- Reset asserted after sample 10 → all outputs return to their reset values next cycle and no write occurs.
- SWITCH_PACKER_TIMEOUT_EN with TIMEOUT_CYCLES=16: 4 samples then permanently empty → timeout_err=1, one write with 4 samples, done pulse.
